// File: rtl/line_buf_pkg.sv
// Shared definitions for the line window buffer: pointer-width helper,
// reader state encoding and default geometry.
package line_buf_pkg;

    localparam int DEF_DATA_W     = 8;
    localparam int DEF_LINE_WIDTH = 16;

    // Reader state: WAIT until enough complete lines exist, then STREAM columns.
    typedef enum logic {
        WAIT   = 1'b0,
        STREAM = 1'b1
    } rd_state_e;

    // Bits needed to hold values 0..n-1 (never narrower than one bit).
    function automatic int ptr_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/line_buf_ring_ptr.sv
// Modulo-N wrap counter. Advances on inc_i and returns to zero after N-1.
// wrap_o flags the increment that takes the counter from N-1 back to 0, so
// the caller can chain a second counter or update an occupancy count.
module line_buf_ring_ptr
    import line_buf_pkg::*;
#(
    parameter int N = 4,
    parameter int W = ptr_w(N)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc_i,
    output logic [W-1:0] value_o,
    output logic         wrap_o
);

    localparam logic [W-1:0] LAST = W'(N - 1);

    logic [W-1:0] value_q;
    logic [W-1:0] value_d;
    logic         at_last;

    assign at_last = (value_q == LAST);
    assign wrap_o  = inc_i && at_last;
    assign value_o = value_q;

    // Next value: explicit compare-and-clear so non-power-of-two N wraps correctly.
    always_comb begin
        value_d = value_q;
        if (inc_i) begin
            value_d = at_last ? '0 : value_q + W'(1);
        end
    end

    // Counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            value_q <= '0;
        end else begin
            value_q <= value_d;
        end
    end

endmodule

// File: rtl/line_window_buffer.sv
// Multi-line ring buffer between the raster pixel source and the convolution
// window stage. Samples are written one per cycle into NUM_LINES line slots;
// once KERNEL_H complete lines are held, each read returns one vertical
// column of KERNEL_H samples (oldest line in the low slice), one cycle later.
// Finishing reading a column row releases the oldest line for rewriting.
// Optional build macro: LINE_WINDOW_BUFFER_OVERFLOW_EN adds a sticky
// 'overflow' output that records any sample dropped while the buffer was full.
module line_window_buffer
    import line_buf_pkg::*;
#(
    parameter int DATA_W     = DEF_DATA_W,
    parameter int LINE_WIDTH = DEF_LINE_WIDTH,
    parameter int NUM_LINES  = 4,
    parameter int KERNEL_H   = 3
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [DATA_W-1:0]                data_in,
    input  logic                             data_valid,
    output logic                             data_ready,
    input  logic                             rd_en,
    output logic                             win_avail,
    output logic [KERNEL_H*DATA_W-1:0]       col_data,
    output logic                             col_valid,
    output logic [ptr_w(LINE_WIDTH)-1:0]     col_idx,
`ifdef LINE_WINDOW_BUFFER_OVERFLOW_EN
    output logic                             overflow,
`endif
    output logic [ptr_w(NUM_LINES+1)-1:0]    lines_full
);

    localparam int COL_W = ptr_w(LINE_WIDTH);
    localparam int LN_W  = ptr_w(NUM_LINES);
    localparam int LF_W  = ptr_w(NUM_LINES + 1);

    localparam logic [LF_W-1:0] NL_C  = LF_W'(NUM_LINES);
    localparam logic [LF_W-1:0] KH_C  = LF_W'(KERNEL_H);
    localparam logic [LN_W:0]   NL_WC = (LN_W+1)'(NUM_LINES);

    // Line storage; deliberately not reset (stale data is never exposed,
    // because only complete, unreleased lines are ever read).
    logic [DATA_W-1:0] mem_q [NUM_LINES][LINE_WIDTH];

    logic [COL_W-1:0] next_wr_col;
    logic [LN_W-1:0]  next_wr_line;
    logic [COL_W-1:0] next_rd_col;
    logic [LN_W-1:0]  rd_base;

    logic wr_acc;
    logic rd_acc;
    logic wr_wrap;
    logic rd_wrap;
    logic unused_wr_line_wrap;
    logic unused_rd_base_wrap;

    logic [LF_W-1:0] lines_full_q;
    logic [LF_W-1:0] lines_full_d;

    rd_state_e state_q;
    rd_state_e state_d;

    logic [KERNEL_H*DATA_W-1:0] col_data_q;
    logic [COL_W-1:0]           col_idx_q;
    logic                       col_valid_q;

    logic [LN_W-1:0] rd_slot [KERNEL_H];

    assign data_ready = (lines_full_q < NL_C);
    assign wr_acc     = data_valid && data_ready;
    assign rd_acc     = rd_en && win_avail;

    // Write column pointer; its wrap marks a completed line.
    line_buf_ring_ptr #(.N(LINE_WIDTH), .W(COL_W)) u_wr_col (
        .clk     (clk),
        .rst     (rst),
        .inc_i   (wr_acc),
        .value_o (next_wr_col),
        .wrap_o  (wr_wrap)
    );

    // Write line slot; advances once per completed line.
    line_buf_ring_ptr #(.N(NUM_LINES), .W(LN_W)) u_wr_line (
        .clk     (clk),
        .rst     (rst),
        .inc_i   (wr_wrap),
        .value_o (next_wr_line),
        .wrap_o  (unused_wr_line_wrap)
    );

    // Read column pointer; its wrap releases the oldest line.
    line_buf_ring_ptr #(.N(LINE_WIDTH), .W(COL_W)) u_rd_col (
        .clk     (clk),
        .rst     (rst),
        .inc_i   (rd_acc),
        .value_o (next_rd_col),
        .wrap_o  (rd_wrap)
    );

    // Oldest held line slot; row stride of one line per completed column sweep.
    line_buf_ring_ptr #(.N(NUM_LINES), .W(LN_W)) u_rd_base (
        .clk     (clk),
        .rst     (rst),
        .inc_i   (rd_wrap),
        .value_o (rd_base),
        .wrap_o  (unused_rd_base_wrap)
    );

    // Physical slot of each kernel row: (rd_base + k) mod NUM_LINES.
    // k < NUM_LINES, so a single conditional subtract is enough.
    generate
        for (genvar gi = 0; gi < KERNEL_H; gi++) begin : g_slot
            logic [LN_W:0] slot_sum;
            assign slot_sum    = {1'b0, rd_base} + (LN_W+1)'(gi);
            assign rd_slot[gi] = (slot_sum >= NL_WC) ? LN_W'(slot_sum - NL_WC)
                                                     : slot_sum[LN_W-1:0];
        end
    endgenerate

    // Sample write into the current line slot.
    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem_q[next_wr_line][next_wr_col] <= data_in;
        end
    end

    // Occupancy: +1 on line completion, -1 on release, unchanged when both coincide.
    always_comb begin
        lines_full_d = lines_full_q;
        if (wr_wrap && !rd_wrap) begin
            lines_full_d = lines_full_q + LF_W'(1);
        end else if (!wr_wrap && rd_wrap) begin
            lines_full_d = lines_full_q - LF_W'(1);
        end
    end

    // Occupancy register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lines_full_q <= '0;
        end else begin
            lines_full_q <= lines_full_d;
        end
    end

    // Reader state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= WAIT;
        end else begin
            state_q <= state_d;
        end
    end

    // Reader next state follows the next occupancy so win_avail never lags a release.
    always_comb begin
        state_d = WAIT;
        if (lines_full_d >= KH_C) begin
            state_d = STREAM;
        end
    end

    // Reader outputs.
    always_comb begin
        win_avail = 1'b0;
        if (state_q == STREAM) begin
            win_avail = 1'b1;
        end
    end

    // Registered column read: one-cycle latency, held between reads.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col_data_q  <= '0;
            col_idx_q   <= '0;
            col_valid_q <= 1'b0;
        end else begin
            col_valid_q <= rd_acc;
            if (rd_acc) begin
                col_idx_q <= next_rd_col;
                for (int k = 0; k < KERNEL_H; k++) begin
                    col_data_q[k*DATA_W +: DATA_W] <= mem_q[rd_slot[k]][next_rd_col];
                end
            end
        end
    end

`ifdef LINE_WINDOW_BUFFER_OVERFLOW_EN
    logic overflow_q;

    // Sticky record of any sample offered while the buffer was full.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow_q <= 1'b0;
        end else if (data_valid && !data_ready) begin
            overflow_q <= 1'b1;
        end
    end

    assign overflow = overflow_q;
`endif

    assign col_data   = col_data_q;
    assign col_idx    = col_idx_q;
    assign col_valid  = col_valid_q;
    assign lines_full = lines_full_q;

endmodule

// File: tb/tb_line_window_buffer.sv
// Self-checking bench for line_window_buffer (DATA_W=8, LINE_WIDTH=4,
// NUM_LINES=4, KERNEL_H=3). The reference model keeps complete lines in a
// queue; a read returns column c of the three oldest queued lines.
module tb_line_window_buffer;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  data_in;
    logic        data_valid;
    logic        data_ready;
    logic        rd_en;
    logic        win_avail;
    logic [23:0] col_data;
    logic        col_valid;
    logic [1:0]  col_idx;
    logic [2:0]  lines_full;
`ifdef LINE_WINDOW_BUFFER_OVERFLOW_EN
    logic        overflow;
`endif

    always #5 clk = ~clk;

    line_window_buffer #(
        .DATA_W     (8),
        .LINE_WIDTH (4),
        .NUM_LINES  (4),
        .KERNEL_H   (3)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .data_in    (data_in),
        .data_valid (data_valid),
        .data_ready (data_ready),
        .rd_en      (rd_en),
        .win_avail  (win_avail),
        .col_data   (col_data),
        .col_valid  (col_valid),
        .col_idx    (col_idx),
`ifdef LINE_WINDOW_BUFFER_OVERFLOW_EN
        .overflow   (overflow),
`endif
        .lines_full (lines_full)
    );

    typedef struct packed {
        logic        ready;
        logic        avail;
        logic [2:0]  lf;
        logic        cv;
        logic [1:0]  idx;
        logic [23:0] col;
    } snap_t;

    typedef logic [7:0] line_t [4];

    line_t m_full[$];
    line_t m_part;
    int    m_pcnt;
    int    m_rcol;

    snap_t exp_s;
    snap_t obs_s;
    int    n_vec = 0;
    int    n_err = 0;

    task automatic model_reset();
        m_full.delete();
        m_pcnt = 0;
        m_rcol = 0;
    endtask

    // One clock cycle: drive inputs, capture pre-edge status and the
    // post-edge column output, and advance the reference model.
    task automatic step(input bit dv, input logic [7:0] din, input bit rd);
        data_valid = dv;
        data_in    = din;
        rd_en      = rd;
        #1;
        exp_s       = '0;
        obs_s       = '0;
        exp_s.ready = (m_full.size() < 4);
        exp_s.avail = (m_full.size() >= 3);
        exp_s.lf    = 3'(m_full.size());
        obs_s.ready = data_ready;
        obs_s.avail = win_avail;
        obs_s.lf    = lines_full;
        if (rd && exp_s.avail) begin
            exp_s.cv  = 1'b1;
            exp_s.idx = 2'(m_rcol);
            exp_s.col = {m_full[2][m_rcol], m_full[1][m_rcol], m_full[0][m_rcol]};
            m_rcol++;
            if (m_rcol == 4) begin
                m_rcol = 0;
                m_full.delete(0);
            end
        end
        if (dv && exp_s.ready) begin
            m_part[m_pcnt] = din;
            m_pcnt++;
            if (m_pcnt == 4) begin
                m_full.push_back(m_part);
                m_pcnt = 0;
            end
        end
        @(posedge clk);
        @(negedge clk);
        obs_s.cv = col_valid;
        if (exp_s.cv) begin
            obs_s.idx = col_idx;
            obs_s.col = col_data;
        end
    endtask

    task automatic do_reset();
        rst        = 1'b1;
        data_valid = 1'b0;
        rd_en      = 1'b0;
        data_in    = '0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        @(negedge clk);
        n_vec++;
        if (lines_full !== 3'd0 || col_valid !== 1'b0 || col_data !== 24'd0 ||
            col_idx !== 2'd0 || data_ready !== 1'b1 || win_avail !== 1'b0) begin
            n_err++;
            $display("FAIL reset got lf=%0d cv=%0b col=%h idx=%0d rdy=%0b av=%0b want lf=0 cv=0 col=000000 idx=0 rdy=1 av=0",
                     lines_full, col_valid, col_data, col_idx, data_ready, win_avail);
        end
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_fill(input string tag);
        for (int i = 0; i < 12; i++) begin
            step(1'b1, 8'(i + 1), 1'b0);
            n_vec++;
            if (obs_s !== exp_s) begin
                n_err++;
                $display("FAIL %s[%0d] got %p want %p", tag, i, obs_s, exp_s);
            end
            if (i % 4 == 0) begin
                n_vec++;
                if (obs_s.lf !== 3'(i / 4)) begin
                    n_err++;
                    $display("FAIL %s_lf[%0d] got %0d want %0d", tag, i, obs_s.lf, i / 4);
                end
            end
        end
        data_valid = 1'b0;
        #1;
        n_vec++;
        if (win_avail !== 1'b1 || lines_full !== 3'd3) begin
            n_err++;
            $display("FAIL %s_end got av=%0b lf=%0d want av=1 lf=3", tag, win_avail, lines_full);
        end
    endtask

    task automatic test_read_columns();
        logic [23:0] golden [4];
        golden[0] = 24'h090501;
        golden[1] = 24'h0a0602;
        golden[2] = 24'h0b0703;
        golden[3] = 24'h0c0804;
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 8'd0, 1'b1);
            n_vec++;
            if (obs_s !== exp_s) begin
                n_err++;
                $display("FAIL read_col[%0d] got %p want %p", i, obs_s, exp_s);
            end
            n_vec++;
            if (col_valid !== 1'b1 || col_data !== golden[i] || col_idx !== 2'(i)) begin
                n_err++;
                $display("FAIL read_golden[%0d] got cv=%0b col=%h idx=%0d want cv=1 col=%h idx=%0d",
                         i, col_valid, col_data, col_idx, golden[i], i);
            end
        end
        rd_en = 1'b0;
        #1;
        n_vec++;
        if (lines_full !== 3'd2 || win_avail !== 1'b0) begin
            n_err++;
            $display("FAIL read_end got lf=%0d av=%0b want lf=2 av=0", lines_full, win_avail);
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        for (int i = 0; i < 16; i++) begin
            step(1'b1, 8'(i + 1), 1'b0);
            n_vec++;
            if (obs_s !== exp_s) begin
                n_err++;
                $display("FAIL bp_fill[%0d] got %p want %p", i, obs_s, exp_s);
            end
        end
        data_valid = 1'b0;
        #1;
        n_vec++;
        if (data_ready !== 1'b0 || lines_full !== 3'd4) begin
            n_err++;
            $display("FAIL bp_full got rdy=%0b lf=%0d want rdy=0 lf=4", data_ready, lines_full);
        end
`ifdef LINE_WINDOW_BUFFER_OVERFLOW_EN
        n_vec++;
        if (overflow !== 1'b0) begin
            n_err++;
            $display("FAIL bp_ovf_pre got %0b want 0", overflow);
        end
`endif
        step(1'b1, 8'd99, 1'b0);
        n_vec++;
        if (obs_s !== exp_s || lines_full !== 3'd4) begin
            n_err++;
            $display("FAIL bp_drop got %p lf=%0d want %p lf=4", obs_s, lines_full, exp_s);
        end
`ifdef LINE_WINDOW_BUFFER_OVERFLOW_EN
        n_vec++;
        if (overflow !== 1'b1) begin
            n_err++;
            $display("FAIL bp_ovf got %0b want 1", overflow);
        end
`endif
        // Drain everything readable; a stored 99 would surface in some column.
        for (int i = 0; i < 12; i++) begin
            step(1'b0, 8'd0, 1'b1);
            n_vec++;
            if (obs_s !== exp_s) begin
                n_err++;
                $display("FAIL bp_drain[%0d] got %p want %p", i, obs_s, exp_s);
            end
        end
    endtask

    task automatic test_simultaneous();
        do_reset();
        for (int i = 0; i < 12; i++) begin
            step(1'b1, 8'(i + 1), 1'b0);
        end
        for (int i = 12; i < 16; i++) begin
            step(1'b1, 8'(i + 1), 1'b1);
            n_vec++;
            if (obs_s !== exp_s) begin
                n_err++;
                $display("FAIL simul[%0d] got %p want %p", i, obs_s, exp_s);
            end
        end
        data_valid = 1'b0;
        rd_en      = 1'b0;
        #1;
        n_vec++;
        if (lines_full !== 3'd3 || win_avail !== 1'b1) begin
            n_err++;
            $display("FAIL simul_lf got lf=%0d av=%0b want lf=3 av=1", lines_full, win_avail);
        end
        step(1'b0, 8'd0, 1'b1);
        n_vec++;
        if (col_valid !== 1'b1 || col_data !== 24'h0d0905 || col_idx !== 2'd0) begin
            n_err++;
            $display("FAIL simul_next got cv=%0b col=%h idx=%0d want cv=1 col=0d0905 idx=0",
                     col_valid, col_data, col_idx);
        end
    endtask

    task automatic test_wraparound();
        int sent;
        int reads;
        do_reset();
        sent  = 0;
        reads = 0;
        for (int i = 0; i < 200 && sent < 40; i++) begin
            step(1'b1, 8'($urandom), 1'b1);
            if (exp_s.ready) sent++;
            if (exp_s.cv) reads++;
            n_vec++;
            if (obs_s !== exp_s) begin
                n_err++;
                $display("FAIL wrap[%0d] got %p want %p", i, obs_s, exp_s);
            end
        end
        for (int i = 0; i < 50; i++) begin
            step(1'b0, 8'd0, 1'b1);
            if (exp_s.cv) reads++;
            n_vec++;
            if (obs_s !== exp_s) begin
                n_err++;
                $display("FAIL wrap_drain[%0d] got %p want %p", i, obs_s, exp_s);
            end
        end
        n_vec++;
        if (sent != 40 || reads != 32) begin
            n_err++;
            $display("FAIL wrap_count got sent=%0d reads=%0d want sent=40 reads=32", sent, reads);
        end
        for (int i = 0; i < 300; i++) begin
            step(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)));
            n_vec++;
            if (obs_s !== exp_s) begin
                n_err++;
                $display("FAIL random[%0d] got %p want %p", i, obs_s, exp_s);
            end
        end
    endtask

    task automatic test_reset_mid_stream();
        do_reset();
        for (int i = 0; i < 20; i++) begin
            step(1'b1, 8'($urandom), 1'b1);
            n_vec++;
            if (obs_s !== exp_s) begin
                n_err++;
                $display("FAIL mid[%0d] got %p want %p", i, obs_s, exp_s);
            end
        end
        data_valid = 1'b0;
        rd_en      = 1'b0;
        n_vec++;
        if (col_valid !== 1'b1) begin
            n_err++;
            $display("FAIL mid_pre got cv=%0b want 1", col_valid);
        end
        #2;
        rst = 1'b1;
        #1;
        n_vec++;
        if (lines_full !== 3'd0 || col_valid !== 1'b0 || data_ready !== 1'b1 || win_avail !== 1'b0) begin
            n_err++;
            $display("FAIL mid_rst got lf=%0d cv=%0b rdy=%0b av=%0b want lf=0 cv=0 rdy=1 av=0",
                     lines_full, col_valid, data_ready, win_avail);
        end
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        test_fill("refill");
    endtask

    initial begin
        rst        = 1'b1;
        data_valid = 1'b0;
        rd_en      = 1'b0;
        data_in    = '0;
        test_reset();
        test_fill("fill");
        test_read_columns();
        test_backpressure();
        test_simultaneous();
        test_wraparound();
        test_reset_mid_stream();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/line_window_buffer.md
Name: line_window_buffer

Overview:
- Parametrised multi-line pixel buffer. Stores NUM_LINES physical lines of LINE_WIDTH samples each, written one sample per cycle as a raster stream.
- Once KERNEL_H complete lines are held, it emits a vertical column of KERNEL_H samples per read request.
- Sits between the pixel source and the convolution window/MAC stage. Succeeds the single-line array filler: adds multi-line ring storage, a read side, flow control and line recycling.

Parameters:
- DATA_W, 8, sample width in bits.
- LINE_WIDTH, 16, samples per line (>=2).
- NUM_LINES, 4, physical line slots (>=KERNEL_H).
- KERNEL_H, 3, lines per output column (>=1).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- data_in  in  DATA_W  write sample.
- data_valid  in  1  write request.
- data_ready  out  1  buffer can accept a sample.
- rd_en  in  1  column read request.
- win_avail  out  1  a column can be read this cycle.
- col_data  out  KERNEL_H*DATA_W  column; slice [DATA_W-1:0] = oldest line, top slice = newest.
- col_valid  out  1  col_data valid (one-cycle pulse per accepted read).
- col_idx  out  clog2(LINE_WIDTH)  column index of col_data.
- lines_full  out  clog2(NUM_LINES+1)  count of complete, unreleased lines.

Behaviour:
- Reset values: all pointers, lines_full, col_data, col_idx and col_valid are 0. Storage is not reset.
- Write pointers: next_wr_col (0..LINE_WIDTH-1) and next_wr_line (0..NUM_LINES-1). Each names the next location to be written, not the last one written.
- data_ready = (lines_full < NUM_LINES), combinational from registers.
- Write accepted when data_valid && data_ready:
  - mem[next_wr_line][next_wr_col] <= data_in; next_wr_col increments.
  - At LINE_WIDTH-1, next_wr_col wraps to 0, next_wr_line advances mod NUM_LINES, and lines_full is incremented (line complete).
- data_valid while !data_ready: the sample is dropped and no state changes.
- Reader FSM:
  - WAIT: lines_full < KERNEL_H; win_avail = 0.
  - STREAM: lines_full >= KERNEL_H; win_avail = 1.
- Read accepted when rd_en && win_avail. rd_en while !win_avail is ignored.
- Next cycle after an accepted read:
  - col_valid = 1.
  - col_data slice k = mem[(rd_base + k) mod NUM_LINES][next_rd_col].
  - col_idx = next_rd_col.
  - Read latency is 1 cycle.
- next_rd_col increments per accepted read. At LINE_WIDTH-1 it wraps to 0, rd_base advances by 1 mod NUM_LINES (row stride 1), and lines_full is decremented (oldest line released).
- Simultaneous line completion and line release in one cycle: lines_full is unchanged. Pointers update independently.
- Writer only touches slot next_wr_line, which is never in the full set. Reader only touches full lines. Read/write hazards therefore cannot occur.
- A released slot becomes writable the cycle after release.
- Pointer arithmetic is modulo, not power-of-two masking; non-power-of-two LINE_WIDTH and NUM_LINES are legal.
- rst asserted mid-operation: all pointers and counts clear immediately; col_valid drops asynchronously. Stored data is stale and is never exposed until rewritten.

Optional Feature:
- Macro LINE_WINDOW_BUFFER_OVERFLOW_EN.
- When defined: adds output overflow (1 bit), sticky. Sets on the cycle after data_valid && !data_ready. Cleared only by rst.
- When undefined: port absent; dropped samples are silent.

Decomposition:
- Shared package line_buf_pkg holds:
  - the pointer-width function (clog2 wrapper);
  - the reader state enum {WAIT, STREAM};
  - defaults for DATA_W and LINE_WIDTH.
- One natural sub-module: line_buf_ring_ptr, a modulo-N wrap counter with inc and wrap outputs. Instantiated for next_wr_col, next_wr_line, next_rd_col and rd_base.

Test Plan:
All scenarios use DATA_W=8, LINE_WIDTH=4, NUM_LINES=4, KERNEL_H=3.
1. Fill: write 12 samples 1..12 with rd_en=0 -> lines_full goes 1, 2, 3 after samples 4, 8, 12; win_avail rises the cycle after sample 12.
2. Read four columns -> col_data = {9,5,1}, {10,6,2}, {11,7,3}, {12,8,4}; col_idx 0..3, each 1 cycle after rd_en; lines_full back to 2; win_avail=0.
3. Backpressure: write 16 samples with no reads -> data_ready=0 after the 16th. A 17th sample (value 99) is dropped. With OVERFLOW_EN defined, overflow=1.
4. Simultaneous: lines_full=3, writer on column 3 of the 4th line while reader reads column 3 in the same cycle -> lines_full stays 3, rd_base=1. The next column read returns lines 2, 3, 4.
5. Wrap-around: stream 40 samples with continuous rd_en -> every emitted column matches the golden model across multiple physical-slot wraps; no sample lost.
6. Reset mid-stream: assert rst during scenario 5 -> lines_full=0, col_valid=0 and data_ready=1 immediately. After release, a fresh 12-sample fill reproduces scenario 1.
